// File: rtl/fetch_pkg.sv
// Shared widths, fetch step and the FIFO entry layout for the fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} entries with flush.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: none internally; the caller's credit logic must never push when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: flush clears pointers and count; otherwise push/pop advance independently.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers; storage is cleared on reset so the head never carries X.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: sequential rom addressing, in-flight tracking, buffered hand-off to cpu; FETCH_BYPASS_EN adds a FIFO bypass.
// Latency: redirect/reset to first inst_valid is 2 cycles, 1 cycle with FETCH_BYPASS_EN.
// Backpressure: inst_ready low fills the FIFO; issue stops once count + in-flight reaches DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;

    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_push_dat;
    logic              fifo_push;
    logic              fifo_pop;
    logic              bypass_hit;
    logic              issue;

    // Fetch addressing and credit check: issue when redirecting or while a slot is still free.
    always_comb begin
        rom_address  = redirect_valid ? redirect_pc : fetch_pc_q;
        issue        = redirect_valid ||
                       (({1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q}) < DEPTH_C);
        pending_d    = issue;
        pending_pc_d = issue ? rom_address : pending_pc_q;
        fetch_pc_d   = issue ? (rom_address + PC_STEP) : fetch_pc_q;
    end

    // Delivery: bypass or FIFO head, push of the returning word, and pop on handshake.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass_hit = (fifo_count == '0) && pending_q && !redirect_valid;
`else
        bypass_hit = 1'b0;
`endif
        inst_valid = ((fifo_count != '0) || bypass_hit) && !redirect_valid;
        inst       = '0;
        inst_pc    = '0;
        if (bypass_hit) begin
            inst    = rom_data;
            inst_pc = pending_pc_q;
        end else if (inst_valid) begin
            inst    = fifo_head.inst;
            inst_pc = fifo_head.pc;
        end
        fifo_push_dat.pc   = pending_pc_q;
        fifo_push_dat.inst = rom_data;
        // A response landing in a redirect cycle belongs to the abandoned stream.
        fifo_push = pending_q && !redirect_valid && !(bypass_hit && inst_ready);
        fifo_pop  = inst_valid && inst_ready && !bypass_hit;
    end

    // Fetch PC and in-flight read tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .count    (fifo_count),
        .head     (fifo_head)
    );

endmodule
